// File: rtl/ram_arb_pkg.sv
// Shared types for the two-master RAM arbiter/controller (ram_arb_ctrl).
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_ADDR = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_t;

endpackage

// File: rtl/ram_rr_arb.sv
// Two-way arbiter: round-robin by default, fixed m0 priority when
// ARB_FIXED_PRIO_EN is defined (the rr pointer then does not exist).
module ram_rr_arb
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

`ifdef ARB_FIXED_PRIO_EN
    logic unused_arb;
    assign unused_arb = clk ^ rst_n ^ accept;

    always_comb begin
        grant = '0;
        if (valid[0]) begin
            grant = 2'b01;
        end else if (valid[1]) begin
            grant = 2'b10;
        end
    end
`else
    owner_t ptr;

    // After each accept the pointer names the master that did not win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= OWN_M0;
        end else if (accept) begin
            ptr <= grant[0] ? OWN_M1 : OWN_M0;
        end
    end

    always_comb begin
        grant = valid;
        if (valid[0] && valid[1]) begin
            grant = (ptr == OWN_M0) ? 2'b01 : 2'b10;
        end
    end
`endif

endmodule

// File: rtl/ram_arb_ctrl.sv
// Two-master valid/ready front end sequencing a single-port registered-read RAM.
// Arbitration mode selected by ARB_FIXED_PRIO_EN (see ram_rr_arb).
module ram_arb_ctrl
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 5,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_valid,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ready,
    output logic                  m0_rsp_valid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_valid,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ready,
    output logic                  m1_rsp_valid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    state_t                state, state_nx;
    logic [1:0]            valid, grant;
    logic                  accept;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [DATA_WIDTH-1:0] wdata_q;
    owner_t                owner_q;
    logic                  drive_en;
    logic                  done;

    assign valid = {m1_valid, m0_valid};

    ram_rr_arb u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (valid),
        .accept (accept),
        .grant  (grant)
    );

    always_comb begin
        m0_ready  = 1'b0;
        m1_ready  = 1'b0;
        accept    = 1'b0;
        state_nx  = state;
        sel_we    = m0_we;
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        if (grant[1]) begin
            sel_we    = m1_we;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
        end
        case (state)
            IDLE: begin
                m0_ready = grant[0];
                m1_ready = grant[1];
                accept   = |grant;
                if (accept) begin
                    state_nx = sel_we ? WR : RD_ADDR;
                end
            end
            WR:      state_nx = IDLE;
            RD_ADDR: state_nx = RD_DATA;
            RD_DATA: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    assign done = (state == WR) || (state == RD_DATA);

    // RAM pins are registered from the next state so they change only on clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_cs       <= 1'b0;
            ram_we       <= 1'b0;
            ram_oe       <= 1'b0;
            drive_en     <= 1'b0;
            ram_address  <= '0;
            wdata_q      <= '0;
            owner_q      <= OWN_M0;
            m0_rsp_valid <= 1'b0;
            m1_rsp_valid <= 1'b0;
            m0_rdata     <= '0;
            m1_rdata     <= '0;
        end else begin
            ram_cs       <= (state_nx != IDLE);
            ram_we       <= (state_nx == WR);
            ram_oe       <= (state_nx == RD_ADDR);
            drive_en     <= (state_nx == WR);
            m0_rsp_valid <= done && (owner_q == OWN_M0);
            m1_rsp_valid <= done && (owner_q == OWN_M1);
            if (accept) begin
                ram_address <= sel_addr;
                wdata_q     <= sel_wdata;
                owner_q     <= grant[1] ? OWN_M1 : OWN_M0;
            end
            if (state == RD_DATA) begin
                if (owner_q == OWN_M0) begin
                    m0_rdata <= ram_data;
                end else begin
                    m1_rdata <= ram_data;
                end
            end
        end
    end

    assign ram_data = drive_en ? wdata_q : 'z;

endmodule

// File: tb/tb_ram_arb_ctrl.sv
// Bench for ram_arb_ctrl with an inline registered-read tri-state RAM and a
// transaction-level model of grants, latencies and memory contents.
module tb_ram_arb_ctrl;

    localparam int DW = 5;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic          m0_valid, m0_we, m1_valid, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ready, m1_ready, m0_rsp_valid, m1_rsp_valid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] ram_address;
    logic          ram_cs, ram_we, ram_oe;
    wire  [DW-1:0] ram_data;

    ram_arb_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m0_valid     (m0_valid),
        .m0_we        (m0_we),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m0_ready     (m0_ready),
        .m0_rsp_valid (m0_rsp_valid),
        .m0_rdata     (m0_rdata),
        .m1_valid     (m1_valid),
        .m1_we        (m1_we),
        .m1_addr      (m1_addr),
        .m1_wdata     (m1_wdata),
        .m1_ready     (m1_ready),
        .m1_rsp_valid (m1_rsp_valid),
        .m1_rdata     (m1_rdata),
        .ram_address  (ram_address),
        .ram_cs       (ram_cs),
        .ram_we       (ram_we),
        .ram_oe       (ram_oe),
        .ram_data     (ram_data)
    );

    // Single-port RAM: write on cs&we, registered read, drives bus while cs&!we
    logic [DW-1:0] ram_mem [32];
    logic [DW-1:0] ram_dout;
    logic          ram_oe_flag;

    always @(posedge clk) begin
        if (ram_cs && ram_we) ram_mem[ram_address] <= ram_data;
        if (ram_cs && !ram_we && ram_oe) ram_dout <= ram_mem[ram_address];
        ram_oe_flag <= ram_cs && !ram_we && ram_oe;
    end

    assign ram_data = (ram_cs && !ram_we && ram_oe_flag) ? ram_dout : 'z;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int            cyc;
    int            free_at;
    int            rr;
    int            last_win;
    logic [DW-1:0] mdl_mem [32];
    logic [DW-1:0] exp_rdata [2];
    logic [AW-1:0] exp_addr;
    bit            p_valid;
    int            p_m;
    bit            p_we;
    logic [DW-1:0] p_val;
    int            p_acc, p_rsp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        p_valid      = 1'b0;
        free_at      = cyc;
        rr           = 0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        exp_addr     = '0;
        last_win     = -1;
    endtask

    task automatic check_cycle();
        int            win;
        int            ph;
        bit            exp_cs;
        logic          a_we;
        logic [AW-1:0] a_addr;
        logic [DW-1:0] a_data;
        @(negedge clk);
        win = -1;
        if (cyc >= free_at) begin
            if (m0_valid && m1_valid) begin
`ifdef ARB_FIXED_PRIO_EN
                win = 0;
`else
                win = rr;
`endif
            end else if (m0_valid) begin
                win = 0;
            end else if (m1_valid) begin
                win = 1;
            end
        end
        if (p_valid && cyc == p_rsp && !p_we) exp_rdata[p_m] = p_val;
        check("m0_ready", 32'(m0_ready), 32'(win == 0));
        check("m1_ready", 32'(m1_ready), 32'(win == 1));
        check("m0_rsp_valid", 32'(m0_rsp_valid), 32'(p_valid && cyc == p_rsp && p_m == 0));
        check("m1_rsp_valid", 32'(m1_rsp_valid), 32'(p_valid && cyc == p_rsp && p_m == 1));
        check("m0_rdata", 32'(m0_rdata), 32'(exp_rdata[0]));
        check("m1_rdata", 32'(m1_rdata), 32'(exp_rdata[1]));
        ph     = p_valid ? cyc - p_acc : 0;
        exp_cs = p_valid && ph >= 1 && cyc < p_rsp;
        check("ram_cs", 32'(ram_cs), 32'(exp_cs));
        check("ram_we", 32'(ram_we), 32'(exp_cs && p_we));
        check("ram_oe", 32'(ram_oe), 32'(exp_cs && !p_we && ph == 1));
        check("ram_address", 32'(ram_address), 32'(exp_addr));
        if (exp_cs && (p_we || ph == 2)) check("ram_data", 32'(ram_data), 32'(p_val));
        if (p_valid && cyc >= p_rsp) p_valid = 1'b0;
        last_win = win;
        if (win >= 0) begin
            a_we   = (win == 0) ? m0_we    : m1_we;
            a_addr = (win == 0) ? m0_addr  : m1_addr;
            a_data = (win == 0) ? m0_wdata : m1_wdata;
            p_valid = 1'b1;
            p_m     = win;
            p_we    = a_we;
            p_val   = a_we ? a_data : mdl_mem[a_addr];
            if (a_we) mdl_mem[a_addr] = a_data;
            p_acc    = cyc;
            p_rsp    = cyc + (a_we ? 2 : 3);
            free_at  = p_rsp;
            exp_addr = a_addr;
            rr       = 1 - win;
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycle();
        check_cycle();
        next_edge();
    endtask

    task automatic set_m(input int m, input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        if (m == 0) begin
            m0_valid = v; m0_we = we; m0_addr = a; m0_wdata = d;
        end else begin
            m1_valid = v; m1_we = we; m1_addr = a; m1_wdata = d;
        end
    endtask

    // Hold a command until the model sees it accepted, then drop valid.
    task automatic xact(input int m, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int  n;
        bit  got;
        got = 1'b0;
        n   = 0;
        set_m(m, 1'b1, we, a, d);
        while (!got && n < 12) begin
            check_cycle();
            got = (last_win == m);
            next_edge();
            n++;
        end
        vectors++;
        assert (got) else begin
            miscompares++;
            $error("FAIL xact_accept observed=%0d expected=1", got);
        end
        set_m(m, 1'b0, we, a, d);
    endtask

    initial begin
        rst_n = 1'b0;
        set_m(0, 1'b0, 1'b0, '0, '0);
        set_m(1, 1'b0, 1'b0, '0, '0);
        cyc = 0;
        for (int i = 0; i < 32; i++) mdl_mem[i] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ram_cs", 32'(ram_cs), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_oe", 32'(ram_oe), 32'd0);
        check("rst_ram_address", 32'(ram_address), 32'd0);
        check("rst_m0_rsp", 32'(m0_rsp_valid), 32'd0);
        check("rst_m1_rdata", 32'(m1_rdata), 32'd0);
        rst_n = 1'b1;
        model_reset();
        repeat (2) cycle();

        // Write then read back on m0
        xact(0, 1'b1, 5'h03, 5'h15);
        xact(0, 1'b0, 5'h03, 5'h00);
        repeat (3) cycle();

        // Back-to-back read, write, read of the same address
        xact(0, 1'b0, 5'h03, 5'h00);
        xact(0, 1'b1, 5'h03, 5'h0A);
        xact(0, 1'b0, 5'h03, 5'h00);
        repeat (3) cycle();

        // Top address written by m1, read by m0
        xact(1, 1'b1, 5'h1F, 5'h1F);
        xact(0, 1'b0, 5'h1F, 5'h00);
        repeat (3) cycle();

        // Both masters valid continuously, then m0 drops out
        set_m(0, 1'b1, 1'b1, 5'h01, 5'h11);
        set_m(1, 1'b1, 1'b1, 5'h02, 5'h0C);
        repeat (12) cycle();
        set_m(0, 1'b0, 1'b1, 5'h01, 5'h11);
        repeat (4) cycle();
        set_m(1, 1'b0, 1'b1, 5'h02, 5'h0C);
        repeat (2) cycle();

        // Initialise every address so random reads have known contents
        for (int i = 0; i < 32; i++) xact(i % 2, 1'b1, 5'(i), 5'($urandom));
        repeat (2) cycle();

        // Random traffic; valids may drop without acceptance
        for (int i = 0; i < 400; i++) begin
            set_m(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom));
            set_m(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom));
            cycle();
        end
        set_m(0, 1'b0, 1'b0, '0, '0);
        set_m(1, 1'b0, 1'b0, '0, '0);
        repeat (4) cycle();

        // Reset asserted during the read data cycle
        xact(0, 1'b0, 5'h03, 5'h00);
        cycle();
        check_cycle();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ram_cs", 32'(ram_cs), 32'd0);
        check("midrst_ram_oe", 32'(ram_oe), 32'd0);
        check("midrst_ram_we", 32'(ram_we), 32'd0);
        check("midrst_ram_address", 32'(ram_address), 32'd0);
        check("midrst_m0_rdata", 32'(m0_rdata), 32'd0);
        next_edge();
        check("midrst_m0_rsp", 32'(m0_rsp_valid), 32'd0);
        rst_n = 1'b1;
        model_reset();
        repeat (4) cycle();
        xact(1, 1'b0, 5'h1F, 5'h00);
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_arb_ctrl.md
Name: ram_arb_ctrl

Overview:
- Two-requester controller/arbiter for the single-port synchronous RAM (address, bidirectional data, cs, we, oe; registered read, tri-stated output).
- Accepts read/write commands from two masters (m0, m1) over valid/ready handshakes, arbitrates round-robin, and sequences RAM cycles.
- Owns the RAM's shared data bus, returns read data with a one-cycle response pulse.
- Sits between datapath masters and the RAM instance; it is the only driver of the RAM control pins.

Parameters:
- DATA_WIDTH, 5, RAM word width; must match the RAM.
- ADDR_WIDTH, 5, RAM address width; must match the RAM.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  asynchronous reset, active low.
- m0_valid / m1_valid  input  1  command valid.
- m0_we / m1_we  input  1  1 = write, 0 = read.
- m0_addr / m1_addr  input  ADDR_WIDTH  command address.
- m0_wdata / m1_wdata  input  DATA_WIDTH  write data.
- m0_ready / m1_ready  output  1  command accepted when valid && ready.
- m0_rsp_valid / m1_rsp_valid  output  1  one-cycle completion pulse (reads and writes).
- m0_rdata / m1_rdata  output  DATA_WIDTH  read data, valid with rsp_valid; held until the next read response.
- ram_address  output  ADDR_WIDTH  to RAM address.
- ram_cs / ram_we / ram_oe  output  1  to RAM chip select, write enable and output enable.
- ram_data  inout  DATA_WIDTH  RAM data bus.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE; rr pointer = m0.
  - ram_cs = ram_we = ram_oe = 0; ram_address = 0; ram_data released (Z).
  - Both ready and rsp_valid = 0; both rdata = 0.
  - Reset mid-transaction aborts it with no response pulse. RAM contents are not touched by the controller.
- States: IDLE, WR, RD_ADDR, RD_DATA.
- IDLE:
  - ready is asserted combinationally only for the grant winner, only in IDLE.
  - Grant rules:
    - One valid: that master wins.
    - Both valid: the master named by the rr pointer wins.
    - None valid: both ready = 0.
  - On accept, register addr, wdata and owner id; the rr pointer moves to the other master.
  - Next state is WR if we = 1, RD_ADDR if we = 0.
- WR (1 cycle):
  - ram_cs = 1, ram_we = 1, ram_oe = 0; ram_address = latched addr; ram_data driven with latched wdata.
  - The RAM writes at the closing edge.
  - The owner's rsp_valid is high in the following cycle; rdata is unchanged. Next state is IDLE.
- RD_ADDR (1 cycle):
  - ram_cs = 1, ram_we = 0, ram_oe = 1; ram_data released.
  - The RAM registers data and sets its output-enable flag at the closing edge.
- RD_DATA (1 cycle):
  - ram_cs = 1 (mandatory: the RAM output buffer requires cs); ram_we = 0, ram_oe = 0.
  - The RAM drives the bus; the controller captures ram_data into the owner's rdata at the closing edge.
  - The owner's rsp_valid is high in the following cycle. Next state is IDLE.
- Bus rule: the controller drives ram_data only in WR (ram_we = 1). The RAM drives only when we = 0, so there is no contention; no turnaround cycle is needed.
- Latency, counted from the accept edge:
  - write: rsp_valid in cycle 2;
  - read: rsp_valid in cycle 3.
- Throughput: one write per 2 cycles, one read per 3 cycles. rsp_valid for a transaction can coincide with ready/accept of the next.
- Handshake:
  - Inputs are sampled only at the accept edge; a master may drop valid without acceptance.
  - A losing master's ready stays 0.
- ram_address holds its last value outside active states; all RAM outputs are registered (no glitches).

Optional Feature:
- ARB_FIXED_PRIO_EN
  - Defined: fixed priority, m0 always wins when both are valid; the rr pointer is not implemented.
  - Undefined (default): round-robin as above.

Decomposition:
- Package ram_arb_pkg holds:
  - state enum (IDLE, WR, RD_ADDR, RD_DATA);
  - owner id type (1 bit, OWN_M0 = 0, OWN_M1 = 1).
- One sub-module, ram_rr_arb: 2-way arbiter with rr pointer and the ARB_FIXED_PRIO_EN variant. Inputs: valids, accept strobe. Outputs: grant one-hot.
- Bench instantiates the real RAM (DATA_WIDTH = 5, ADDR_WIDTH = 5) with tri-state ram_data.

Test Plan:
- Reset checks:
  - Release reset → all RAM controls 0, ram_data = Z, ready = 0 with no valid.
  - Assert rst_n low during RD_DATA → outputs return to reset values immediately, no rsp_valid pulse.
- m0 write addr 0x03 data 0x15, then m0 read 0x03 → write rsp_valid 2 cycles after accept; read rsp_valid 3 cycles after accept with m0_rdata = 0x15.
- m0 and m1 both valid continuously, writing addr 0x01/0x02 → grants alternate m0, m1, m0, m1; each ready pulses only in IDLE.
- m1 write 0x1F to 0x1F (top address), m0 read 0x1F → m0_rdata = 0x1F, m1_rdata unchanged; no X/contention on ram_data throughout.
- Back-to-back read 0x03 then write 0x03 = 0x0A then read 0x03 → 0x15 then 0x0A; ram_cs held 1 through RD_DATA.
- With ARB_FIXED_PRIO_EN: both valid for 4 transactions → m0 granted all 4, m1 granted only after m0_valid drops.
